// File: rtl/pcie_vc_switch_if.sv
// Bus bundle for pcie_vc_switch: ingress, egress, threshold configuration and counter read-back.
// The switch uses the slave view; a driver or bench uses the master view.
interface pcie_vc_switch_if #(
  parameter int DATA_W       = 12,
  parameter int NUM_CLASS    = 4,
  parameter int NUM_DEST     = 4,
  parameter int UMBRALES_L_H = 8,
  parameter int CNT_W        = 8
);
  localparam int DST_W = $clog2(NUM_DEST);

  logic                       init;
  logic [UMBRALES_L_H-1:0]    umbral_L;
  logic [UMBRALES_L_H-1:0]    umbral_H;
  logic                       push;
  logic [DATA_W-1:0]          data_in;
  logic [NUM_CLASS-1:0]       in_almost_full;
  logic [NUM_DEST-1:0]        pop;
  logic [NUM_DEST*DATA_W-1:0] data_out;
  logic [NUM_DEST-1:0]        out_valid;
  logic [NUM_DEST-1:0]        out_almost_empty;
  logic [NUM_DEST-1:0]        out_empty;
  logic                       req;
  logic [DST_W-1:0]           idx;
  logic [CNT_W-1:0]           cnt_data;
  logic                       cnt_valid;
  logic                       idle;
  logic                       error;
  logic [1:0]                 state;

  modport master (
    output init, umbral_L, umbral_H, push, data_in, pop, req, idx,
    input  in_almost_full, data_out, out_valid, out_almost_empty, out_empty,
           cnt_data, cnt_valid, idle, error, state
  );

  modport slave (
    input  init, umbral_L, umbral_H, push, data_in, pop, req, idx,
    output in_almost_full, data_out, out_valid, out_almost_empty, out_empty,
           cnt_data, cnt_valid, idle, error, state
  );
endinterface

// File: rtl/pcie_vc_switch.sv
// Class-to-destination switch: per-class ingress FIFOs, arbiter into per-dest egress FIFOs,
// threshold config FSM and delivery counters. Define STRICT_PRIO_EN for fixed-priority arbitration.
module pcie_vc_switch #(
  parameter int DATA_W       = 12,
  parameter int NUM_CLASS    = 4,
  parameter int NUM_DEST     = 4,
  parameter int DEPTH        = 8,
  parameter int UMBRALES_L_H = 8,
  parameter int CNT_W        = 8
) (
  input  logic            clk,
  input  logic            reset,
  pcie_vc_switch_if.slave bus
);
  localparam int CLS_W = $clog2(NUM_CLASS);
  localparam int DST_W = $clog2(NUM_DEST);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int TH_W  = UMBRALES_L_H;

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_INIT   = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;
  localparam logic [1:0] ST_ACTIVE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TH_W-1:0]  th_l_q, th_l_d, th_h_q, th_h_d;
  logic [CLS_W-1:0] last_grant_q, last_grant_d;

  logic [DATA_W-1:0] cls_mem_q [NUM_CLASS][DEPTH];
  logic [DATA_W-1:0] cls_mem_d [NUM_CLASS][DEPTH];
  logic [PTR_W-1:0]  cls_wr_q [NUM_CLASS], cls_wr_d [NUM_CLASS];
  logic [PTR_W-1:0]  cls_rd_q [NUM_CLASS], cls_rd_d [NUM_CLASS];
  logic [OCC_W-1:0]  cls_occ_q [NUM_CLASS], cls_occ_d [NUM_CLASS];

  logic [DATA_W-1:0] dst_mem_q [NUM_DEST][DEPTH];
  logic [DATA_W-1:0] dst_mem_d [NUM_DEST][DEPTH];
  logic [PTR_W-1:0]  dst_wr_q [NUM_DEST], dst_wr_d [NUM_DEST];
  logic [PTR_W-1:0]  dst_rd_q [NUM_DEST], dst_rd_d [NUM_DEST];
  logic [OCC_W-1:0]  dst_occ_q [NUM_DEST], dst_occ_d [NUM_DEST];

  logic [CNT_W-1:0]           cnt_q [NUM_DEST], cnt_d [NUM_DEST];
  logic [NUM_DEST*DATA_W-1:0] data_out_q, data_out_d;
  logic [NUM_DEST-1:0]        out_valid_q, out_valid_d;
  logic [CNT_W-1:0]           cnt_data_q, cnt_data_d;
  logic                       cnt_valid_q, cnt_valid_d;
  logic                       error_q, error_d;

  logic [DATA_W-1:0]    head_word [NUM_CLASS];
  logic [DST_W-1:0]     head_dst [NUM_CLASS];
  logic [NUM_CLASS-1:0] eligible, cls_ne, cls_af, cls_push_v, cls_pop_v;
  logic [NUM_DEST-1:0]  dst_ne, dst_af, dst_ae, dst_push_v, dst_pop_v;
  logic                 arb_en, grant_vld, push_ok, push_drop, pop_bad;
  logic [CLS_W-1:0]     grant_cls, push_cls;
  logic [DATA_W-1:0]    grant_word;
  logic [DST_W-1:0]     grant_dst;
`ifndef STRICT_PRIO_EN
  logic [CLS_W-1:0]     cand;
`endif

  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      cls_ne[c]    = cls_occ_q[c] != '0;
      cls_af[c]    = TH_W'(cls_occ_q[c]) >= th_h_q;
      head_word[c] = cls_mem_q[c][cls_rd_q[c]];
      head_dst[c]  = head_word[c][DATA_W-1-CLS_W -: DST_W];
    end
    for (int d = 0; d < NUM_DEST; d++) begin
      dst_ne[d] = dst_occ_q[d] != '0;
      dst_af[d] = TH_W'(dst_occ_q[d]) >= th_h_q;
      dst_ae[d] = TH_W'(dst_occ_q[d]) <= th_l_q;
    end
    for (int c = 0; c < NUM_CLASS; c++)
      eligible[c] = cls_ne[c] && !dst_af[head_dst[c]];
  end

  // Inconsistent thresholds (L >= H, or H beyond the FIFO depth) fall back to the defaults.
  always_comb begin
    state_d = state_q;
    th_l_d  = th_l_q;
    th_h_d  = th_h_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (bus.umbral_L >= bus.umbral_H || bus.umbral_H > TH_W'(DEPTH)) begin
          th_l_d = TH_W'(1);
          th_h_d = TH_W'(DEPTH - 2);
        end else begin
          th_l_d = bus.umbral_L;
          th_h_d = bus.umbral_H;
        end
        if (!bus.init) state_d = ST_IDLE;
      end
      ST_IDLE:   if (bus.init) state_d = ST_INIT;
                 else if (|cls_ne || |dst_ne) state_d = ST_ACTIVE;
      ST_ACTIVE: if (bus.init) state_d = ST_INIT;
                 else if (!(|cls_ne || |dst_ne)) state_d = ST_IDLE;
      default:   state_d = ST_RESET;
    endcase
  end

  // Descending loops so the last hit is the highest-priority candidate.
  always_comb begin
    arb_en    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    grant_vld = 1'b0;
    grant_cls = '0;
`ifdef STRICT_PRIO_EN
    for (int i = NUM_CLASS - 1; i >= 0; i--) begin
      if (arb_en && eligible[i]) begin
        grant_vld = 1'b1;
        grant_cls = CLS_W'(i);
      end
    end
`else
    cand = '0;
    for (int i = NUM_CLASS; i >= 1; i--) begin
      cand = last_grant_q + CLS_W'(i);
      if (arb_en && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_cls = cand;
      end
    end
`endif
    grant_word   = head_word[grant_cls];
    grant_dst    = head_dst[grant_cls];
    last_grant_d = grant_vld ? grant_cls : last_grant_q;
  end

  always_comb begin
    cls_mem_d  = cls_mem_q;
    cls_wr_d   = cls_wr_q;
    cls_rd_d   = cls_rd_q;
    cls_occ_d  = cls_occ_q;
    dst_mem_d  = dst_mem_q;
    dst_wr_d   = dst_wr_q;
    dst_rd_d   = dst_rd_q;
    dst_occ_d  = dst_occ_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    out_valid_d = '0;
    cls_push_v = '0;
    cls_pop_v  = '0;
    dst_push_v = '0;
    dst_pop_v  = '0;
    pop_bad    = 1'b0;
    push_ok    = 1'b0;
    push_drop  = 1'b0;
    push_cls   = bus.data_in[DATA_W-1 -: CLS_W];
    if (bus.push && state_q != ST_RESET) begin
      if (cls_occ_q[push_cls] == OCC_W'(DEPTH)) push_drop = 1'b1;
      else                                      push_ok   = 1'b1;
    end
    for (int c = 0; c < NUM_CLASS; c++) begin
      cls_push_v[c] = push_ok && (push_cls == CLS_W'(c));
      cls_pop_v[c]  = grant_vld && (grant_cls == CLS_W'(c));
      if (cls_push_v[c]) begin
        cls_mem_d[c][cls_wr_q[c]] = bus.data_in;
        cls_wr_d[c] = cls_wr_q[c] + PTR_W'(1);
      end
      if (cls_pop_v[c]) cls_rd_d[c] = cls_rd_q[c] + PTR_W'(1);
      cls_occ_d[c] = cls_occ_q[c] + OCC_W'(cls_push_v[c]) - OCC_W'(cls_pop_v[c]);
    end
    for (int d = 0; d < NUM_DEST; d++) begin
      dst_push_v[d] = grant_vld && (grant_dst == DST_W'(d));
      dst_pop_v[d]  = bus.pop[d] && dst_ne[d];
      if (bus.pop[d] && !dst_ne[d]) pop_bad = 1'b1;
      if (dst_push_v[d]) begin
        dst_mem_d[d][dst_wr_q[d]] = grant_word;
        dst_wr_d[d] = dst_wr_q[d] + PTR_W'(1);
      end
      if (dst_pop_v[d]) begin
        data_out_d[d*DATA_W +: DATA_W] = dst_mem_q[d][dst_rd_q[d]];
        out_valid_d[d] = 1'b1;
        dst_rd_d[d]    = dst_rd_q[d] + PTR_W'(1);
        cnt_d[d]       = cnt_q[d] + CNT_W'(1);
      end
      dst_occ_d[d] = dst_occ_q[d] + OCC_W'(dst_push_v[d]) - OCC_W'(dst_pop_v[d]);
    end
    error_d     = push_drop | pop_bad;
    cnt_valid_d = bus.req;
    cnt_data_d  = bus.req ? cnt_q[bus.idx] : cnt_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      th_l_q       <= TH_W'(1);
      th_h_q       <= TH_W'(DEPTH - 2);
      last_grant_q <= CLS_W'(NUM_CLASS - 1);
      for (int c = 0; c < NUM_CLASS; c++) begin
        cls_wr_q[c]  <= '0;
        cls_rd_q[c]  <= '0;
        cls_occ_q[c] <= '0;
      end
      for (int d = 0; d < NUM_DEST; d++) begin
        dst_wr_q[d]  <= '0;
        dst_rd_q[d]  <= '0;
        dst_occ_q[d] <= '0;
        cnt_q[d]     <= '0;
      end
      data_out_q  <= '0;
      out_valid_q <= '0;
      cnt_data_q  <= '0;
      cnt_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      th_l_q       <= th_l_d;
      th_h_q       <= th_h_d;
      last_grant_q <= last_grant_d;
      cls_wr_q     <= cls_wr_d;
      cls_rd_q     <= cls_rd_d;
      cls_occ_q    <= cls_occ_d;
      dst_wr_q     <= dst_wr_d;
      dst_rd_q     <= dst_rd_d;
      dst_occ_q    <= dst_occ_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      cnt_data_q   <= cnt_data_d;
      cnt_valid_q  <= cnt_valid_d;
      error_q      <= error_d;
    end
  end

  // Storage needs no reset: zeroed pointers and occupancies make stale entries unreachable.
  always_ff @(posedge clk) begin
    cls_mem_q <= cls_mem_d;
    dst_mem_q <= dst_mem_d;
  end

  assign bus.in_almost_full   = cls_af;
  assign bus.out_almost_empty = dst_ae;
  assign bus.out_empty        = ~dst_ne;
  assign bus.data_out         = data_out_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.cnt_data         = cnt_data_q;
  assign bus.cnt_valid        = cnt_valid_q;
  assign bus.idle             = (state_q == ST_IDLE);
  assign bus.error            = error_q;
  assign bus.state            = state_q;
endmodule

// File: tb/tb_pcie_vc_switch.sv
// Directed bench for pcie_vc_switch with hand-computed expectations (4 classes, 4 dests, depth 8).
// Expected grant order follows STRICT_PRIO_EN when it is defined.
module tb_pcie_vc_switch;
  logic clk;
  logic reset;
  int   check_count = 0;
  int   error_count = 0;
  logic [11:0] grant_exp [8];

  pcie_vc_switch_if #(
    .DATA_W(12), .NUM_CLASS(4), .NUM_DEST(4), .UMBRALES_L_H(8), .CNT_W(8)
  ) bus ();

  pcie_vc_switch #(
    .DATA_W(12), .NUM_CLASS(4), .NUM_DEST(4), .DEPTH(8), .UMBRALES_L_H(8), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the end of the test sequence");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, wait for the edge, then release the strobes.
  task automatic applyStimulus(input logic p, input logic [11:0] w, input logic [3:0] pp,
                               input logic rq, input logic [1:0] ix);
    bus.push    = p;
    bus.data_in = w;
    bus.pop     = pp;
    bus.req     = rq;
    bus.idx     = ix;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = '0;
    bus.req  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 12'h000, 4'b0000, 1'b0, 2'd0);
  endtask

  initial begin
`ifdef STRICT_PRIO_EN
    grant_exp = '{12'h000, 12'h001, 12'h410, 12'h411, 12'h820, 12'h821, 12'hC30, 12'hC31};
`else
    grant_exp = '{12'h000, 12'h410, 12'h820, 12'hC30, 12'h001, 12'h411, 12'h821, 12'hC31};
`endif
    reset        = 1'b1;
    bus.init     = 1'b0;
    bus.umbral_L = 8'd0;
    bus.umbral_H = 8'd0;
    bus.push     = 1'b0;
    bus.data_in  = '0;
    bus.pop      = '0;
    bus.req      = 1'b0;
    bus.idx      = '0;
    #2;
    waitCycles(2);

    $display("[TB] reset values");
    checkOutput("rst_state", bus.state, 2'd0);
    checkOutput("rst_out_empty", bus.out_empty, 4'hF);
    checkOutput("rst_out_aempty", bus.out_almost_empty, 4'hF);
    checkOutput("rst_in_afull", bus.in_almost_full, 4'h0);
    checkOutput("rst_data_out", bus.data_out, 48'h0);
    checkOutput("rst_out_valid", bus.out_valid, 4'h0);
    checkOutput("rst_cnt_valid", bus.cnt_valid, 1'b0);
    checkOutput("rst_cnt_data", bus.cnt_data, 8'h0);
    checkOutput("rst_error", bus.error, 1'b0);
    checkOutput("rst_idle", bus.idle, 1'b0);

    $display("[TB] configuration L=2 H=6");
    reset        = 1'b0;
    bus.init     = 1'b1;
    bus.umbral_L = 8'd2;
    bus.umbral_H = 8'd6;
    waitCycles(1);
    checkOutput("cfg_state_init", bus.state, 2'd1);
    waitCycles(2);
    bus.init = 1'b0;
    waitCycles(1);
    checkOutput("cfg_state_idle", bus.state, 2'd2);
    checkOutput("cfg_idle", bus.idle, 1'b1);
    checkOutput("cfg_in_afull", bus.in_almost_full, 4'h0);
    checkOutput("cfg_out_aempty", bus.out_almost_empty, 4'hF);

    $display("[TB] single word 0xA5C to dest 2");
    applyStimulus(1'b1, 12'hA5C, 4'b0000, 1'b0, 2'd0);
    checkOutput("one_empty_t1", bus.out_empty[2], 1'b1);
    checkOutput("one_state_t1", bus.state, 2'd2);
    waitCycles(1);
    checkOutput("one_empty_t2", bus.out_empty[2], 1'b0);
    checkOutput("one_state_t2", bus.state, 2'd3);
    applyStimulus(1'b0, 12'h000, 4'b0100, 1'b0, 2'd0);
    checkOutput("one_data", bus.data_out[24 +: 12], 12'hA5C);
    checkOutput("one_valid", bus.out_valid, 4'b0100);
    checkOutput("one_empty_after", bus.out_empty, 4'hF);
    applyStimulus(1'b0, 12'h000, 4'b0000, 1'b1, 2'd2);
    checkOutput("one_cnt_data", bus.cnt_data, 8'd1);
    checkOutput("one_cnt_valid", bus.cnt_valid, 1'b1);
    checkOutput("one_valid_drop", bus.out_valid, 4'h0);
    checkOutput("one_idle", bus.idle, 1'b1);
    waitCycles(1);
    checkOutput("one_cnt_valid_low", bus.cnt_valid, 1'b0);
    checkOutput("one_cnt_hold", bus.cnt_data, 8'd1);

    $display("[TB] fill class 1 toward dest 3");
    bus.init = 1'b1;
    waitCycles(1);
    checkOutput("fill_state_init", bus.state, 2'd1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 12'h700 + 12'(k), 4'b0000, 1'b0, 2'd0);
      if (k == 4) checkOutput("fill_afull_5", bus.in_almost_full, 4'b0000);
      if (k == 5) checkOutput("fill_afull_6", bus.in_almost_full, 4'b0010);
    end
    checkOutput("fill_no_error", bus.error, 1'b0);
    applyStimulus(1'b1, 12'h708, 4'b0000, 1'b0, 2'd0);
    checkOutput("fill_drop_error", bus.error, 1'b1);
    waitCycles(1);
    checkOutput("fill_error_pulse", bus.error, 1'b0);
    bus.init = 1'b0;
    waitCycles(1);
    checkOutput("fill_state_idle", bus.state, 2'd2);
    waitCycles(10);
    checkOutput("fill_state_active", bus.state, 2'd3);
    checkOutput("fill_in_afull_rem", bus.in_almost_full, 4'b0000);
    checkOutput("fill_out_empty", bus.out_empty, 4'b0111);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 12'h000, 4'b1000, 1'b0, 2'd0);
      checkOutput($sformatf("drain3_data_%0d", k), bus.data_out[36 +: 12], 12'h700 + 12'(k));
      checkOutput($sformatf("drain3_valid_%0d", k), bus.out_valid, 4'b1000);
      if (k == 4) checkOutput("drain3_aempty_occ3", bus.out_almost_empty[3], 1'b0);
      if (k == 5) checkOutput("drain3_aempty_occ2", bus.out_almost_empty[3], 1'b1);
    end
    checkOutput("drain3_empty", bus.out_empty[3], 1'b1);
    applyStimulus(1'b0, 12'h000, 4'b1000, 1'b0, 2'd0);
    checkOutput("empty_pop_error", bus.error, 1'b1);
    checkOutput("empty_pop_valid", bus.out_valid, 4'h0);
    checkOutput("empty_pop_hold", bus.data_out[36 +: 12], 12'h707);
    applyStimulus(1'b0, 12'h000, 4'b0000, 1'b1, 2'd3);
    checkOutput("cnt3_after_drain", bus.cnt_data, 8'd8);
    applyStimulus(1'b0, 12'h000, 4'b0000, 1'b1, 2'd2);
    checkOutput("cnt2_after_drain", bus.cnt_data, 8'd1);

    $display("[TB] bad thresholds L=5 H=3");
    bus.init     = 1'b1;
    bus.umbral_L = 8'd5;
    bus.umbral_H = 8'd3;
    waitCycles(1);
    checkOutput("dflt_state_init", bus.state, 2'd1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 12'h050 + 12'(k), 4'b0000, 1'b0, 2'd0);
      if (k == 2) checkOutput("dflt_afull_3", bus.in_almost_full, 4'b0000);
      if (k == 4) checkOutput("dflt_afull_5", bus.in_almost_full, 4'b0000);
      if (k == 5) checkOutput("dflt_afull_6", bus.in_almost_full, 4'b0001);
    end
    bus.init = 1'b0;
    waitCycles(11);
    checkOutput("dflt_out_empty", bus.out_empty, 4'b1110);
    checkOutput("dflt_aempty_full", bus.out_almost_empty[0], 1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 12'h000, 4'b0001, 1'b0, 2'd0);
      checkOutput($sformatf("drain0_data_%0d", k), bus.data_out[0 +: 12], 12'h050 + 12'(k));
      if (k == 3) checkOutput("dflt_aempty_occ2", bus.out_almost_empty[0], 1'b0);
      if (k == 4) checkOutput("dflt_aempty_occ1", bus.out_almost_empty[0], 1'b1);
    end
    checkOutput("drain0_empty", bus.out_empty[0], 1'b1);

    $display("[TB] reset with words in flight");
    applyStimulus(1'b1, 12'h850, 4'b0000, 1'b0, 2'd0);
    applyStimulus(1'b1, 12'h960, 4'b0000, 1'b0, 2'd0);
    reset = 1'b1;
    applyStimulus(1'b1, 12'h470, 4'b0001, 1'b0, 2'd0);
    checkOutput("mid_rst_empty", bus.out_empty, 4'hF);
    checkOutput("mid_rst_state", bus.state, 2'd0);
    checkOutput("mid_rst_afull", bus.in_almost_full, 4'h0);
    checkOutput("mid_rst_data", bus.data_out, 48'h0);
    checkOutput("mid_rst_valid", bus.out_valid, 4'h0);
    checkOutput("mid_rst_error", bus.error, 1'b0);
    reset        = 1'b0;
    bus.init     = 1'b1;
    bus.umbral_L = 8'd1;
    bus.umbral_H = 8'd8;
    applyStimulus(1'b1, 12'h0FF, 4'b0000, 1'b1, 2'd3);
    checkOutput("post_rst_state", bus.state, 2'd1);
    checkOutput("post_rst_push_err", bus.error, 1'b0);
    checkOutput("post_rst_cnt_valid", bus.cnt_valid, 1'b1);
    checkOutput("post_rst_cnt3", bus.cnt_data, 8'd0);

    $display("[TB] arbitration order");
    waitCycles(1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, grant_exp[k], 4'b0000, 1'b0, 2'd0);
    end
    bus.init = 1'b0;
    waitCycles(12);
    checkOutput("arb_out_empty", bus.out_empty, 4'b1110);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 12'h000, 4'b0001, 1'b0, 2'd0);
      checkOutput($sformatf("arb_order_%0d", k), bus.data_out[0 +: 12],
`ifdef STRICT_PRIO_EN
                  64'(k < 2 ? 12'h000 + 12'(k) : k < 4 ? 12'h410 + 12'(k - 2) :
                      k < 6 ? 12'h820 + 12'(k - 4) : 12'hC30 + 12'(k - 6)));
`else
                  64'((k % 4 == 0 ? 12'h000 : k % 4 == 1 ? 12'h410 : k % 4 == 2 ? 12'h820 : 12'hC30)
                      + 12'(k / 4)));
`endif
    end
    applyStimulus(1'b0, 12'h000, 4'b0001, 1'b0, 2'd0);
    checkOutput("arb_extra_pop_error", bus.error, 1'b1);
    checkOutput("arb_extra_pop_valid", bus.out_valid, 4'h0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end
endmodule
